// File: rtl/controller_pipeline.sv
// Pipelined RV32I main controller: D-stage decode, D/E, E/M, M/W control registers, hazard and forward logic.
// Optional macro ILLEGAL_TRAP_EN: sticky illegal_e plus flush on an illegal instruction in E.
module controller_pipeline #(
  parameter int REG_ADDR_W         = 5,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_d,
  input  logic                  cond_true_e,
  output logic [2:0]            imm_src_d,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  alu_src_e,
  output logic                  alu_a_pc_e,
  output logic [1:0]            alu_op_e,
  output logic [2:0]            f3_e,
  output logic                  f7b5_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic [1:0]            pc_src_e,
  output logic                  mem_write_m,
  output logic [REG_ADDR_W-1:0] rd_m,
  output logic                  reg_write_w,
  output logic [1:0]            result_src_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic                  illegal_e
);

  logic [6:0] op_d;
  logic [2:0] f3_d;
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
  logic rw_d, alu_src_d, alu_a_pc_d, mw_d, branch_d, jump_d, jalr_d, illegal_d;
  logic [1:0] alu_op_d, rsrc_d;

  logic rw_e, mw_e, branch_e, jump_e, jalr_e, ill_in_e;
  logic [1:0] rsrc_e;
  logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e;
  logic rw_m;
  logic [1:0] rsrc_m;
  logic lw_stall, taken, flush_e, trap_flush;

  assign op_d  = instr_d[6:0];
  assign f3_d  = instr_d[14:12];
  assign rd_d  = REG_ADDR_W'(instr_d[11:7]);
  assign rs1_d = REG_ADDR_W'(instr_d[19:15]);
  assign rs2_d = REG_ADDR_W'(instr_d[24:20]);

  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] a, input logic [REG_ADDR_W-1:0] b);
    return (a == b) && !(ZERO_REG_HARDWIRED && (a == '0));
  endfunction

  always_comb begin
    rw_d = 1'b0; imm_src_d = 3'b000; alu_src_d = 1'b0; alu_a_pc_d = 1'b0;
    alu_op_d = 2'b00; rsrc_d = 2'b00; mw_d = 1'b0;
    branch_d = 1'b0; jump_d = 1'b0; jalr_d = 1'b0; illegal_d = 1'b0;
    case (op_d)
      7'd51:  begin rw_d = 1'b1; alu_op_d = 2'b10; end
      7'd3:   begin rw_d = 1'b1; alu_src_d = 1'b1; rsrc_d = 2'b01; end
      7'd19:  begin rw_d = 1'b1; alu_src_d = 1'b1; alu_op_d = 2'b11; end
      7'd35:  begin imm_src_d = 3'b001; alu_src_d = 1'b1; mw_d = 1'b1; end
      7'd99:  begin
        // f3 010/011 are not branch types; treat like an unknown opcode
        if (f3_d == 3'b010 || f3_d == 3'b011) illegal_d = 1'b1;
        else begin imm_src_d = 3'b010; alu_op_d = 2'b01; branch_d = 1'b1; end
      end
      7'd111: begin rw_d = 1'b1; imm_src_d = 3'b011; rsrc_d = 2'b10; jump_d = 1'b1; end
      7'd103: begin rw_d = 1'b1; alu_src_d = 1'b1; rsrc_d = 2'b10; jalr_d = 1'b1; end
      7'd55:  begin rw_d = 1'b1; imm_src_d = 3'b100; rsrc_d = 2'b11; end
      7'd23:  begin rw_d = 1'b1; imm_src_d = 3'b100; alu_src_d = 1'b1; alu_a_pc_d = 1'b1; end
      default: illegal_d = 1'b1;
    endcase
  end

  always_comb begin
    if (jalr_e)                                   pc_src_e = 2'b10;
    else if (jump_e || (branch_e && cond_true_e)) pc_src_e = 2'b01;
    else                                          pc_src_e = 2'b00;
  end

  assign taken    = (pc_src_e != 2'b00);
  assign lw_stall = (rsrc_e == 2'b01) && rw_e && (reg_match(rd_e, rs1_d) || reg_match(rd_e, rs2_d));
`ifdef ILLEGAL_TRAP_EN
  assign trap_flush = ill_in_e;
`else
  assign trap_flush = 1'b0;
`endif
  assign stall_f = lw_stall;
  assign stall_d = lw_stall;
  assign flush_e = lw_stall | taken | trap_flush;
  assign flush_d = taken | trap_flush;

  always_comb begin
    forward_a_e = 2'b00;
    if (rw_m && reg_match(rd_m, rs1_e))      forward_a_e = 2'b10;
    else if (reg_write_w && reg_match(rd_w, rs1_e)) forward_a_e = 2'b01;
    forward_b_e = 2'b00;
    if (rw_m && reg_match(rd_m, rs2_e))      forward_b_e = 2'b10;
    else if (reg_write_w && reg_match(rd_w, rs2_e)) forward_b_e = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_e <= 1'b0; rsrc_e <= 2'b00; mw_e <= 1'b0; branch_e <= 1'b0; jump_e <= 1'b0;
      jalr_e <= 1'b0; alu_src_e <= 1'b0; alu_a_pc_e <= 1'b0; alu_op_e <= 2'b00;
      f3_e <= 3'b000; f7b5_e <= 1'b0; rs1_e <= '0; rs2_e <= '0; rd_e <= '0; ill_in_e <= 1'b0;
      rw_m <= 1'b0; rsrc_m <= 2'b00; mem_write_m <= 1'b0; rd_m <= '0;
      reg_write_w <= 1'b0; result_src_w <= 2'b00; rd_w <= '0;
    end else begin
      if (flush_e) begin
        rw_e <= 1'b0; rsrc_e <= 2'b00; mw_e <= 1'b0; branch_e <= 1'b0; jump_e <= 1'b0;
        jalr_e <= 1'b0; alu_src_e <= 1'b0; alu_a_pc_e <= 1'b0; alu_op_e <= 2'b00;
        f3_e <= 3'b000; f7b5_e <= 1'b0; rs1_e <= '0; rs2_e <= '0; rd_e <= '0; ill_in_e <= 1'b0;
      end else begin
        rw_e <= rw_d; rsrc_e <= rsrc_d; mw_e <= mw_d; branch_e <= branch_d; jump_e <= jump_d;
        jalr_e <= jalr_d; alu_src_e <= alu_src_d; alu_a_pc_e <= alu_a_pc_d; alu_op_e <= alu_op_d;
        f3_e <= f3_d; f7b5_e <= instr_d[30]; rs1_e <= rs1_d; rs2_e <= rs2_d; rd_e <= rd_d;
        ill_in_e <= illegal_d;
      end
      rw_m <= rw_e; rsrc_m <= rsrc_e; mem_write_m <= mw_e; rd_m <= rd_e;
      reg_write_w <= rw_m; result_src_w <= rsrc_m; rd_w <= rd_m;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     illegal_e <= 1'b0;
    else if (illegal_d && !flush_e) illegal_e <= 1'b1;
  end
`else
  assign illegal_e = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{instr_d[31], instr_d[29:25], ill_in_e};

endmodule

// File: tb/tb_controller_pipeline.sv
// Directed bench for controller_pipeline: hazards, forwarding, control transfer, decode fields, reset.
module tb_controller_pipeline;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_d = 32'h0000_0013;
  logic        cond_true_e = 1'b0;
  logic [2:0]  imm_src_d;
  logic        stall_f, stall_d, flush_d, alu_src_e, alu_a_pc_e, f7b5_e;
  logic [1:0]  alu_op_e, forward_a_e, forward_b_e, pc_src_e, result_src_w;
  logic [2:0]  f3_e;
  logic        mem_write_m, reg_write_w, illegal_e;
  logic [4:0]  rd_m, rd_w;
  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic        trap;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] LW5    = {12'd0, 5'd1, 3'b010, 5'd5, 7'd3};
  localparam logic [31:0] ADD6   = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'd51};
  localparam logic [31:0] ADD3   = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'd51};
  localparam logic [31:0] SUB4   = {7'h20, 5'd3, 5'd3, 3'b000, 5'd4, 7'd51};
  localparam logic [31:0] BEQ    = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'd99};
  localparam logic [31:0] JALR   = {12'd0, 5'd2, 3'b000, 5'd1, 7'd103};
  localparam logic [31:0] ADD0   = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'd51};
  localparam logic [31:0] ADD3X0 = {7'd0, 5'd0, 5'd0, 3'b000, 5'd3, 7'd51};
  localparam logic [31:0] AUIPC  = {20'd1, 5'd7, 7'd23};
  localparam logic [31:0] LUI8   = {20'h12345, 5'd8, 7'd55};
  localparam logic [31:0] ILL    = 32'h0000_007F;

  controller_pipeline #(.REG_ADDR_W(5), .ZERO_REG_HARDWIRED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .cond_true_e(cond_true_e),
    .imm_src_d(imm_src_d), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .alu_src_e(alu_src_e), .alu_a_pc_e(alu_a_pc_e), .alu_op_e(alu_op_e), .f3_e(f3_e),
    .f7b5_e(f7b5_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .pc_src_e(pc_src_e), .mem_write_m(mem_write_m), .rd_m(rd_m),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w), .rd_w(rd_w),
    .illegal_e(illegal_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ILLEGAL_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    #2;
    chk("rst_stall", {31'd0, stall_f}, 0);
    chk("rst_alu_op", {30'd0, alu_op_e}, 0);
    chk("rst_rw_w", {31'd0, reg_write_w}, 0);
    chk("rst_pc_src", {30'd0, pc_src_e}, 0);
    #20 rst_n = 1'b1;
    step(); step();

    // load-use
    instr_d = LW5; #1;
    chk("lw_imm", {29'd0, imm_src_d}, 3'b000);
    step();
    instr_d = ADD6; #1;
    chk("lu_stall_f", {31'd0, stall_f}, 1);
    chk("lu_stall_d", {31'd0, stall_d}, 1);
    chk("lu_flush_d", {31'd0, flush_d}, 0);
    chk("lw_alu_src", {31'd0, alu_src_e}, 1);
    step();
    chk("lu_bubble", {30'd0, alu_op_e}, 0);
    chk("lu_stall_end", {31'd0, stall_f}, 0);
    step();
    chk("lu_fwd_a", {30'd0, forward_a_e}, 2'b01);
    chk("lu_fwd_b", {30'd0, forward_b_e}, 2'b00);
    chk("lw_rsrc_w", {30'd0, result_src_w}, 2'b01);
    chk("lw_rd_w", {27'd0, rd_w}, 5);
    chk("add_alu_op", {30'd0, alu_op_e}, 2'b10);

    // EX-to-EX forwarding
    instr_d = ADD3; step();
    instr_d = SUB4; #1;
    chk("sub_nostall", {31'd0, stall_f}, 0);
    step();
    chk("sub_fwd_a", {30'd0, forward_a_e}, 2'b10);
    chk("sub_fwd_b", {30'd0, forward_b_e}, 2'b10);
    chk("sub_f7b5", {31'd0, f7b5_e}, 1);

    // branch
    instr_d = BEQ; #1;
    chk("beq_imm", {29'd0, imm_src_d}, 3'b010);
    step();
    cond_true_e = 1'b0; #1;
    chk("beq_nt_pc", {30'd0, pc_src_e}, 2'b00);
    chk("beq_nt_flush", {31'd0, flush_d}, 0);
    chk("beq_alu_op", {30'd0, alu_op_e}, 2'b01);
    cond_true_e = 1'b1; #1;
    chk("beq_t_pc", {30'd0, pc_src_e}, 2'b01);
    chk("beq_t_flush", {31'd0, flush_d}, 1);
    instr_d = ADD3; step();
    cond_true_e = 1'b0;
    chk("beq_flush_e", {30'd0, alu_op_e}, 2'b00);

    // jalr
    instr_d = JALR; #1;
    chk("jalr_imm", {29'd0, imm_src_d}, 3'b000);
    step();
    chk("jalr_pc", {30'd0, pc_src_e}, 2'b10);
    chk("jalr_flush_d", {31'd0, flush_d}, 1);
    instr_d = NOP; step();
    chk("jalr_rd_m", {27'd0, rd_m}, 1);
    step();
    chk("jalr_rw_w", {31'd0, reg_write_w}, 1);
    chk("jalr_rsrc_w", {30'd0, result_src_w}, 2'b10);
    chk("jalr_rd_w", {27'd0, rd_w}, 1);

    // x0 never forwards
    instr_d = ADD0; step();
    instr_d = ADD3X0; step();
    chk("x0_fwd_a", {30'd0, forward_a_e}, 2'b00);
    chk("x0_fwd_b", {30'd0, forward_b_e}, 2'b00);

    // auipc, lui
    instr_d = AUIPC; #1;
    chk("auipc_imm", {29'd0, imm_src_d}, 3'b100);
    step();
    chk("auipc_a_pc", {31'd0, alu_a_pc_e}, 1);
    chk("auipc_src", {31'd0, alu_src_e}, 1);
    chk("auipc_op", {30'd0, alu_op_e}, 2'b00);
    instr_d = LUI8; step();
    instr_d = NOP; step(); step();
    chk("lui_rsrc_w", {30'd0, result_src_w}, 2'b11);
    chk("lui_rd_w", {27'd0, rd_w}, 8);

    // illegal opcode
    instr_d = ILL; #1;
    chk("ill_imm", {29'd0, imm_src_d}, 3'b000);
    step();
    instr_d = NOP; #1;
    chk("ill_op_e", {30'd0, alu_op_e}, 2'b00);
    chk("ill_flag", {31'd0, illegal_e}, {31'd0, trap});
    chk("ill_flush", {31'd0, flush_d}, {31'd0, trap});
    step(); step();
    chk("ill_sticky", {31'd0, illegal_e}, {31'd0, trap});
    chk("ill_flush_end", {31'd0, flush_d}, 0);

    // asynchronous reset while stalled
    instr_d = LW5; step();
    instr_d = ADD6; #1;
    chk("pre_rst_stall", {31'd0, stall_f}, 1);
    #2 rst_n = 1'b0; #1;
    chk("arst_stall", {31'd0, stall_f}, 0);
    chk("arst_alu_src", {31'd0, alu_src_e}, 0);
    chk("arst_rd_m", {27'd0, rd_m}, 0);
    chk("arst_rw_w", {31'd0, reg_write_w}, 0);
    chk("arst_ill", {31'd0, illegal_e}, 0);
    #10 rst_n = 1'b1;
    instr_d = ADD3; step();
    chk("post_rst_op", {30'd0, alu_op_e}, 2'b10);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/controller_pipeline.md
Name: controller_pipeline

Overview:
- Next-generation main controller for the pipelined RV32I core: decodes in D, carries control through D/E, E/M and M/W registers, and owns hazard detection and forwarding-select generation.
- Extends the combinational decoder with auipc, full branch-type export, load-use stall, flush on taken control transfer, and an illegal-opcode flag.
- Sits between instruction-fetch/decode registers and the datapath muxes.

Parameters:
- REG_ADDR_W, 5: width of rs1/rs2/rd fields and internal tracking.
- ZERO_REG_HARDWIRED, 1: when 1, register 0 never matches for stall or forward comparisons.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_d  in  32  instruction in D: opcode [6:0], rd [11:7], f3 [14:12], rs1 [19:15], rs2 [24:20], f7 [31:25].
- cond_true_e  in  1  datapath branch-compare result for f3_e.
- imm_src_d  out  3  immediate select (D, combinational).
- stall_f, stall_d  out  1  hold PC and IF/ID register.
- flush_d  out  1  clear IF/ID register.
- alu_src_e, alu_a_pc_e  out  1  ALU B=imm; ALU A=PC (auipc).
- alu_op_e  out  2  00 add, 01 sub/compare, 10 R-type, 11 I-ALU.
- f3_e  out  3; f7b5_e  out  1  to ALU decoder and branch comparator.
- forward_a_e, forward_b_e  out  2  00 regfile, 01 W result, 10 M ALU result.
- pc_src_e  out  2  00 PC+4, 01 PC+imm (branch/jal), 10 ALU result (jalr).
- mem_write_m  out  1; rd_m  out  REG_ADDR_W.
- reg_write_w  out  1; result_src_w  out  2 (00 ALU, 01 mem, 10 PC+4, 11 imm); rd_w  out  REG_ADDR_W.
- illegal_e  out  1  illegal instruction in E.

Behaviour:
- Decode table, D stage, combinational:
  - 51 R: rw=1, alu_op=10.
  - 3 load: rw=1, imm=000, alu_src=1, rsrc=01.
  - 19 I-ALU: rw=1, imm=000, alu_src=1, alu_op=11.
  - 35 store: imm=001, alu_src=1, mw=1.
  - 99 branch: imm=010, alu_op=01, branch=1.
  - 111 jal: rw=1, imm=011, rsrc=10, jump=1.
  - 103 jalr: rw=1, imm=000, alu_src=1, rsrc=10, jalr=1.
  - 55 lui: rw=1, imm=100, rsrc=11.
  - 23 auipc: rw=1, imm=100, alu_src=1, alu_a_pc=1.
  - Any other opcode: all controls 0, illegal=1.
- Branch f3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu. f3 010/011 on opcode 99 is illegal.
- pc_src_e: 10 if jalr_e; else 01 if jump_e or (branch_e and cond_true_e); else 00. Taken = pc_src_e != 00.
- Load-use stall (lw_stall), combinational: rsrc_e==01 and reg_write_e and rd_e matches rs1_d or rs2_d (excluding 0 when ZERO_REG_HARDWIRED=1).
  - stall_f = stall_d = lw_stall.
  - flush_e = lw_stall or taken.
  - flush_d = taken.
- Forward A (B identical using rs2_e):
  - 10 if reg_write_m and rd_m==rs1_e.
  - else 01 if reg_write_w and rd_w==rs1_e.
  - else 00.
  - Zero-register exclusion applies. M has priority over W.
- Pipeline registers update every rising clk:
  - D/E loads decoded controls plus rs1/rs2/rd/f3/f7b5.
  - flush_e loads all-zero controls (bubble); rd/rs fields are also zeroed.
  - E/M and M/W always advance; never stalled.
- Latency: D-decoded control reaches E 1 cycle later, M 2 cycles later, W 3 cycles later.
- lw_stall and taken never coincide: they need a load and a control transfer in E at the same time. If both are asserted anyway, flush_d=1 and flush_e=1 still hold.
- Reset (rst_n=0, asynchronous): all pipeline registers clear to 0. All registered outputs read 0, so forwards are 00 and pc_src_e=00. Reset asserted mid-stall discards the stalled state immediately.
- On deassertion, the first valid decode enters E on the following edge.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - illegal_e is registered from D decode.
  - An illegal instruction in E forces flush_d=1 and flush_e=1 for that cycle.
  - illegal_e is sticky until reset.
- Undefined:
  - illegal_e is tied to 0.
  - Illegal opcodes pass as all-zero bubbles with no flush.

Test Plan:
- lw x5 then add x6,x5,x1 back-to-back -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; next cycle forward_a_e=01.
- add x3,x1,x2 then sub x4,x3,x3 -> forward_a_e=forward_b_e=10 in the sub's E cycle; no stall.
- beq with cond_true_e=1 -> pc_src_e=01, flush_d=flush_e=1. Same instruction with cond_true_e=0 -> pc_src_e=00, no flush.
- jalr x1,0(x2) -> pc_src_e=10, reg_write_w=1, result_src_w=10 and rd_w=1 three cycles after D.
- add x0,x1,x2 then add x3,x0,x0 with ZERO_REG_HARDWIRED=1 -> forwards 00.
- Opcode 0x7F with ILLEGAL_TRAP_EN -> illegal_e=1 and stays 1; rst_n low mid-run -> all outputs 0 asynchronously.
